multicycle_controller: RTL and testbench

Main control unit for the multi-cycle ARM processor. It decodes the instruction-register fields exported by `multicycle_datapath` (Cond, Op, Funct, Rd, Zero_bit) and drives every datapath control input through a Moore state machine. It also holds the architectural Z flag and evaluates the condition code. It sits directly upstream of the datapath and shares its clock and reset.

---
 rtl/multicycle_controller_if.sv | 46 ++++
 rtl/multicycle_controller.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle ARM controller and its datapath: IR fields in,
// every datapath strobe and mux select out.
interface multicycle_controller_if;
  // Instruction-register fields and ALU status from the datapath
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       Zero_bit;

  // Write strobes
  logic       pc_write_enable;
  logic       IR_write_enable;
  logic       reg_file_write_enable;
  logic       memory_write_enable;

  // Mux selects and ALU control
  logic       address_select;
  logic       ALUsrcA;
  logic       shifter_input_select;
  logic       shifter_type_select;
  logic       shifter_amount_select;
  logic       dest_selectR14;
  logic [1:0] ALUsrcB;
  logic [1:0] RegSrc;
  logic [1:0] ImmSrc;
  logic [1:0] result_mux_select;
  logic [3:0] Alu_operation_select;
  logic [3:0] state_out;

  modport master (
    input  Cond, Op, Funct, Rd, Zero_bit,
    output pc_write_enable, IR_write_enable, reg_file_write_enable, memory_write_enable,
    output address_select, ALUsrcA, shifter_input_select, shifter_type_select,
    output shifter_amount_select, dest_selectR14,
    output ALUsrcB, RegSrc, ImmSrc, result_mux_select, Alu_operation_select, state_out
  );

  modport slave (
    output Cond, Op, Funct, Rd, Zero_bit,
    input  pc_write_enable, IR_write_enable, reg_file_write_enable, memory_write_enable,
    input  address_select, ALUsrcA, shifter_input_select, shifter_type_select,
    input  shifter_amount_select, dest_selectR14,
    input  ALUsrcB, RegSrc, ImmSrc, result_mux_select, Alu_operation_select, state_out
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle ARM core: decodes IR fields, evaluates the condition
// code against the held Z flag and drives all datapath strobes and selects.
module multicycle_controller (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StExecR    = 4'd2,
    StExecI    = 4'd3,
    StAluWb    = 4'd4,
    StMemAdr   = 4'd5,
    StMemRead  = 4'd6,
    StMemWb    = 4'd7,
    StMemWrite = 4'd8,
    StLink     = 4'd9,
    StBranch   = 4'd10
  } state_e;

  localparam logic [3:0] AluAdd = 4'b0100;
  localparam logic [3:0] AluSub = 4'b0010;

  state_e state_q, state_d;
  logic   z_q;
  logic   cond_pass;
  logic   alu_writes_rd;

  logic       pc_we, ir_we, rf_we, mem_we;
  logic       addr_sel, src_a, dest_r14;
  logic [1:0] src_b, reg_src, imm_src, res_sel;
  logic [3:0] alu_op;

  always_comb begin
    case (bus.Cond)
      4'b0000: cond_pass = z_q;
      4'b0001: cond_pass = ~z_q;
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // TST/TEQ/CMP/CMN only set flags
  assign alu_writes_rd = (bus.Funct[4:3] != 2'b10);

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        if (!cond_pass) begin
          state_d = StFetch;
        end else begin
          case (bus.Op)
            2'b00:   state_d = bus.Funct[5] ? StExecI : StExecR;
            2'b01:   state_d = StMemAdr;
            2'b10:   state_d = bus.Funct[4] ? StLink : StBranch;
            default: state_d = StFetch;
          endcase
        end
      end
      StExecR, StExecI: state_d = StAluWb;
      StMemAdr:         state_d = bus.Funct[0] ? StMemRead : StMemWrite;
      StMemRead:        state_d = StMemWb;
      StLink:           state_d = StBranch;
      default:          state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StExecR || state_q == StExecI) && bus.Funct[0]) begin
        z_q <= bus.Zero_bit;
      end
    end
  end

  always_comb begin
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    src_a    = 1'b0;
    dest_r14 = 1'b0;
    src_b    = 2'b00;
    reg_src  = 2'b00;
    imm_src  = 2'b00;
    res_sel  = 2'b00;
    alu_op   = AluAdd;
    case (state_q)
      StFetch: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        src_a   = 1'b1;
        src_b   = 2'b10;
        res_sel = 2'b10;
      end
      StDecode: begin
        src_a   = 1'b1;
        src_b   = 2'b10;
        res_sel = 2'b10;
        imm_src = bus.Op;
        reg_src = {bus.Op == 2'b10, bus.Op == 2'b01};
      end
      StExecR: alu_op = bus.Funct[4:1];
      StExecI: begin
        src_b  = 2'b01;
        alu_op = bus.Funct[4:1];
      end
      StAluWb: begin
        rf_we = alu_writes_rd;
        pc_we = alu_writes_rd && (bus.Rd == 4'hf);
      end
      StMemAdr: begin
        src_b   = 2'b01;
        imm_src = 2'b01;
        reg_src = 2'b01;
        alu_op  = bus.Funct[3] ? AluAdd : AluSub;
      end
      StMemRead: addr_sel = 1'b1;
      StMemWb: begin
        rf_we   = 1'b1;
        res_sel = 2'b01;
        pc_we   = (bus.Rd == 4'hf);
      end
      StMemWrite: begin
        addr_sel = 1'b1;
        reg_src  = 2'b01;
        mem_we   = 1'b1;
      end
      // R14 <= R15 - 4
      StLink: begin
        reg_src  = 2'b10;
        src_b    = 2'b10;
        alu_op   = AluSub;
        res_sel  = 2'b10;
        dest_r14 = 1'b1;
        rf_we    = 1'b1;
      end
      StBranch: begin
        reg_src = 2'b10;
        src_b   = 2'b01;
        imm_src = 2'b10;
        res_sel = 2'b10;
        pc_we   = 1'b1;
      end
      default: ;
    endcase
    // No write may escape while reset is held
    if (reset) begin
      pc_we  = 1'b0;
      ir_we  = 1'b0;
      rf_we  = 1'b0;
      mem_we = 1'b0;
    end
  end

  assign bus.pc_write_enable       = pc_we;
  assign bus.IR_write_enable       = ir_we;
  assign bus.reg_file_write_enable = rf_we;
  assign bus.memory_write_enable   = mem_we;
  assign bus.address_select        = addr_sel;
  assign bus.ALUsrcA               = src_a;
  assign bus.shifter_input_select  = 1'b0;
  assign bus.shifter_type_select   = 1'b0;
  assign bus.shifter_amount_select = 1'b0;
  assign bus.dest_selectR14        = dest_r14;
  assign bus.ALUsrcB               = src_b;
  assign bus.RegSrc                = reg_src;
  assign bus.ImmSrc                = imm_src;
  assign bus.result_mux_select     = res_sel;
  assign bus.Alu_operation_select  = alu_op;
  assign bus.state_out             = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model predicts the state walk and
// every control output per cycle; directed instructions also pin hand-computed literals.
module tb_multicycle_controller;

  localparam int P_ST = 0, P_ALU = 4, P_RES = 8, P_IMM = 10, P_REG = 12, P_SRCB = 14;
  localparam int P_D14 = 16, P_SRCA = 20, P_ASEL = 21, P_MW = 22, P_RFW = 23, P_IRW = 24;
  localparam int P_PCW = 25;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [25:0] act_vec;
  assign act_vec = {bus.pc_write_enable, bus.IR_write_enable, bus.reg_file_write_enable,
                    bus.memory_write_enable, bus.address_select, bus.ALUsrcA,
                    bus.shifter_input_select, bus.shifter_type_select,
                    bus.shifter_amount_select, bus.dest_selectR14, bus.ALUsrcB, bus.RegSrc,
                    bus.ImmSrc, bus.result_mux_select, bus.Alu_operation_select,
                    bus.state_out};

  logic [25:0] exp_vec, lit_mask, lit_val;
  logic        check_en = 1'b0;
  logic        lit_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        model_z;
  logic [25:0] lit_m[8];
  logic [25:0] lit_v[8];
  int          n_lit = 0;

  always @(negedge clk) begin
    if (check_en) begin
      n_checks++;
      if (act_vec === exp_vec) n_pass++;
      else $display("FAIL outputs st=%0d: got %h want %h", exp_vec[3:0], act_vec, exp_vec);
      if (lit_en) begin
        n_checks++;
        if ((act_vec & lit_mask) === lit_val) n_pass++;
        else $display("FAIL literal pin: got %h want %h (mask %h)", act_vec & lit_mask,
                      lit_val, lit_mask);
      end
    end
  end

  function automatic logic [25:0] fm(input int lsb, input int w);
    logic [25:0] one;
    one = 26'd1;
    return ((one << w) - 26'd1) << lsb;
  endfunction

  function automatic logic [25:0] fv(input int lsb, input int v);
    return 26'(v) << lsb;
  endfunction

  // Control outputs each state must show, straight from the state action table
  function automatic logic [25:0] model_out(input int st, input logic [1:0] op,
                                            input logic [5:0] f, input logic [3:0] rd,
                                            input logic rst);
    logic pcw, irw, rfw, mw, asel, srca, d14;
    logic [1:0] srcb, regsrc, imm, res;
    logic [3:0] alu, stv;
    pcw = 0; irw = 0; rfw = 0; mw = 0; asel = 0; srca = 0; d14 = 0;
    srcb = 0; regsrc = 0; imm = 0; res = 0; alu = 4'b0100;
    stv = st[3:0];
    case (st)
      0: begin irw = 1; pcw = 1; srca = 1; srcb = 2; res = 2; end
      1: begin srca = 1; srcb = 2; res = 2; imm = op; regsrc = {op == 2'd2, op == 2'd1}; end
      2: alu = f[4:1];
      3: begin srcb = 1; alu = f[4:1]; end
      4: begin rfw = (f[4:3] != 2'b10); pcw = rfw && (rd == 4'hf); end
      5: begin srcb = 1; imm = 1; regsrc = 1; alu = f[3] ? 4'b0100 : 4'b0010; end
      6: asel = 1;
      7: begin rfw = 1; res = 1; pcw = (rd == 4'hf); end
      8: begin asel = 1; regsrc = 1; mw = 1; end
      9: begin regsrc = 2; srcb = 2; alu = 4'b0010; res = 2; d14 = 1; rfw = 1; end
      10: begin regsrc = 2; srcb = 1; imm = 2; res = 2; pcw = 1; end
      default: ;
    endcase
    if (rst) begin pcw = 0; irw = 0; rfw = 0; mw = 0; end
    return {pcw, irw, rfw, mw, asel, srca, 1'b0, 1'b0, 1'b0, d14, srcb, regsrc, imm, res,
            alu, stv};
  endfunction

  task automatic set_lit(input int i, input logic [25:0] m, input logic [25:0] v);
    lit_m[i] = m;
    lit_v[i] = v;
    if (i + 1 > n_lit) n_lit = i + 1;
  endtask

  task automatic pin_state(input int i, input int s);
    set_lit(i, fm(P_ST, 4), fv(P_ST, s));
  endtask

  // Runs one instruction from its FETCH cycle; call at posedge+1 with the DUT in FETCH.
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd,
                           input int zb_mode, input int abort_at);
    int   path[$];
    logic pass;
    logic zb;
    bus.Cond  = cond;
    bus.Op    = op;
    bus.Funct = funct;
    bus.Rd    = rd;
    pass = (cond == 4'b0000) ? model_z : (cond == 4'b0001) ? !model_z : (cond == 4'b1110);
    path = {0, 1};
    if (pass) begin
      case (op)
        2'd0: begin path.push_back(funct[5] ? 3 : 2); path.push_back(4); end
        2'd1: begin
          path.push_back(5);
          if (funct[0]) begin path.push_back(6); path.push_back(7); end
          else path.push_back(8);
        end
        2'd2: begin
          if (funct[4]) path.push_back(9);
          path.push_back(10);
        end
        default: ;
      endcase
    end
    for (int i = 0; i < path.size(); i++) begin
      zb = (zb_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(zb_mode);
      bus.Zero_bit = zb;
      if (i == abort_at) begin
        #2 reset = 1'b1;
        exp_vec  = model_out(0, op, funct, rd, 1'b1);
        lit_mask = fm(P_ST, 4) | fm(P_MW, 4);
        lit_val  = '0;
        lit_en   = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_z = 1'b0;
        lit_en  = 1'b0;
        n_lit   = 0;
        return;
      end
      exp_vec = model_out(path[i], op, funct, rd, 1'b0);
      lit_en  = (i < n_lit);
      if (i < 8) begin
        lit_mask = lit_m[i];
        lit_val  = lit_v[i];
      end
      @(posedge clk);
      #1;
      if ((path[i] == 2 || path[i] == 3) && funct[0]) model_z = zb;
    end
    n_lit  = 0;
    lit_en = 1'b0;
  endtask

  initial begin
    logic [3:0] c, r;
    int         ab;
    reset        = 1'b1;
    bus.Cond     = 4'he;
    bus.Op       = 2'd0;
    bus.Funct    = 6'd0;
    bus.Rd       = 4'd0;
    bus.Zero_bit = 1'b0;
    model_z      = 1'b0;
    exp_vec      = model_out(0, 2'd0, 6'd0, 4'd0, 1'b1);
    check_en     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // ADD immediate
    set_lit(0, fm(P_ST, 4) | fm(P_IRW, 1) | fm(P_PCW, 1) | fm(P_SRCA, 1) | fm(P_SRCB, 2) |
               fm(P_ALU, 4),
            fv(P_IRW, 1) | fv(P_PCW, 1) | fv(P_SRCA, 1) | fv(P_SRCB, 2) | fv(P_ALU, 4));
    pin_state(1, 1);
    set_lit(2, fm(P_ST, 4) | fm(P_SRCB, 2) | fm(P_ALU, 4),
            fv(P_ST, 3) | fv(P_SRCB, 1) | fv(P_ALU, 4));
    set_lit(3, fm(P_ST, 4) | fm(P_RFW, 1) | fm(P_RES, 2), fv(P_ST, 4) | fv(P_RFW, 1));
    run_instr(4'he, 2'd0, 6'b101000, 4'd3, -1, -1);

    // CMP reg sets Z, then BEQ is taken
    pin_state(0, 0); pin_state(1, 1); pin_state(2, 2);
    set_lit(3, fm(P_ST, 4) | fm(P_RFW, 1), fv(P_ST, 4));
    run_instr(4'he, 2'd0, 6'b010101, 4'd0, 1, -1);
    pin_state(0, 0); pin_state(1, 1);
    set_lit(2, fm(P_ST, 4) | fm(P_PCW, 1), fv(P_ST, 10) | fv(P_PCW, 1));
    run_instr(4'h0, 2'd2, 6'b100000, 4'd0, -1, -1);

    // CMP clears Z, BEQ retires as NOP
    run_instr(4'he, 2'd0, 6'b010101, 4'd0, 0, -1);
    pin_state(0, 0);
    set_lit(1, fm(P_ST, 4) | fm(P_MW, 4), fv(P_ST, 1));
    run_instr(4'h0, 2'd2, 6'b100000, 4'd0, -1, -1);

    // LDR
    pin_state(0, 0); pin_state(1, 1);
    set_lit(2, fm(P_ST, 4) | fm(P_ALU, 4), fv(P_ST, 5) | fv(P_ALU, 4));
    set_lit(3, fm(P_ST, 4) | fm(P_ASEL, 1), fv(P_ST, 6) | fv(P_ASEL, 1));
    set_lit(4, fm(P_ST, 4) | fm(P_RFW, 1) | fm(P_RES, 2),
            fv(P_ST, 7) | fv(P_RFW, 1) | fv(P_RES, 1));
    run_instr(4'he, 2'd1, 6'b011001, 4'd2, -1, -1);

    // STR with U=0
    pin_state(0, 0); pin_state(1, 1);
    set_lit(2, fm(P_ST, 4) | fm(P_ALU, 4), fv(P_ST, 5) | fv(P_ALU, 2));
    set_lit(3, fm(P_ST, 4) | fm(P_MW, 1), fv(P_ST, 8) | fv(P_MW, 1));
    run_instr(4'he, 2'd1, 6'b010000, 4'd2, -1, -1);
    set_lit(0, fm(P_ST, 4) | fm(P_MW, 1), fv(P_ST, 0));
    run_instr(4'he, 2'd3, 6'b000000, 4'd0, -1, -1);

    // BL
    pin_state(0, 0); pin_state(1, 1);
    set_lit(2, fm(P_ST, 4) | fm(P_D14, 1) | fm(P_ALU, 4) | fm(P_RFW, 1),
            fv(P_ST, 9) | fv(P_D14, 1) | fv(P_ALU, 2) | fv(P_RFW, 1));
    pin_state(3, 10);
    run_instr(4'he, 2'd2, 6'b110000, 4'd0, -1, -1);

    // Set Z, then reset in the middle of a BL's LINK; Z must come back cleared
    run_instr(4'he, 2'd0, 6'b010101, 4'd0, 1, -1);
    run_instr(4'he, 2'd2, 6'b110000, 4'd0, -1, 2);
    pin_state(0, 0); pin_state(1, 1);
    run_instr(4'h0, 2'd2, 6'b100000, 4'd0, -1, -1);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: c = 4'h0;
        1: c = 4'h1;
        2: c = 4'he;
        default: c = 4'($urandom);
      endcase
      r  = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom);
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(c, 2'($urandom), 6'($urandom), r, -1, ab);
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
